// File: rtl/mapa_pkg.sv
// -----------------------------------------------------------------------------
// mapa_pkg
// Shared definitions for the map write arbiter: cell codes stored in the map,
// coordinate/data widths, the controller state encoding, the bundled write
// command and a bounds helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mapa_pkg;

    localparam int COORD_W = 10;
    localparam int DADO_W  = 4;

    // Codes written into map cells
    typedef enum logic [DADO_W-1:0] {
        NADA      = 4'd0,
        COBRA     = 4'd1,
        FRUTA     = 4'd2,
        OBSTACULO = 4'd3
    } celula_e;

    // Controller states
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_LIMPANDO = 1'b1
    } estado_e;

    // One map write as offered by a requester
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [DADO_W-1:0]  dado;
    } escrita_t;

    // True when coordinate c lies strictly below the map dimension lim
    function automatic logic dentro_limite(input logic [COORD_W-1:0] c,
                                           input int unsigned        lim);
        return ({22'd0, c} < lim);
    endfunction

endpackage

// File: rtl/rr_arbitro3.sv
// -----------------------------------------------------------------------------
// rr_arbitro3
// Three-way round-robin arbiter. Request 0 has priority out of reset; after a
// grant, the requester following the granted one becomes top priority.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (priority back to request 0)
//   req    in   [2:0] requests (already masked for eligibility by the parent)
//   grant  out  [2:0] one-hot grant, combinational from req and pointer
// -----------------------------------------------------------------------------
module rr_arbitro3 (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] grant
);

    logic [1:0] prio_q;
    logic [1:0] prio_d;

    // Pick the first active request starting from the priority pointer
    always_comb begin
        grant = 3'b000;
        case (prio_q)
            2'd1: begin
                if (req[1]) begin
                    grant = 3'b010;
                end else if (req[2]) begin
                    grant = 3'b100;
                end else if (req[0]) begin
                    grant = 3'b001;
                end else begin
                    grant = 3'b000;
                end
            end
            2'd2: begin
                if (req[2]) begin
                    grant = 3'b100;
                end else if (req[0]) begin
                    grant = 3'b001;
                end else if (req[1]) begin
                    grant = 3'b010;
                end else begin
                    grant = 3'b000;
                end
            end
            default: begin
                if (req[0]) begin
                    grant = 3'b001;
                end else if (req[1]) begin
                    grant = 3'b010;
                end else if (req[2]) begin
                    grant = 3'b100;
                end else begin
                    grant = 3'b000;
                end
            end
        endcase
    end

    // Advance the pointer past the winner; hold it when nobody is granted
    always_comb begin
        prio_d = prio_q;
        case (grant)
            3'b001:  prio_d = 2'd1;
            3'b010:  prio_d = 2'd2;
            3'b100:  prio_d = 2'd0;
            default: prio_d = prio_q;
        endcase
    end

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 2'd0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mapa_arbitro.sv
// -----------------------------------------------------------------------------
// mapa_arbitro
// Shares the single map write port between three requesters (cobra, fruta,
// obstaculo) with round-robin arbitration, and can sweep the whole map to
// NADA. All outputs are registered: a request sampled at one edge shows up as
// ack + write in the following cycle.
// Parameters:
//   MAPA_WIDTH   map columns
//   MAPA_HEIGHT  map rows
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   <req>_req/_x/_y/_dado          write request, target cell and cell code
//   <req>_ack                      one-cycle write-accepted pulse
//   limpar_start                   request a full-map clear
//   limpar_busy / limpar_done      clear write in progress / completion pulse
//   mem_we/mem_x/mem_y/mem_dado    map write port
//   fora_limite                    pulse when an accepted write was dropped
//                                  for being outside the map
// -----------------------------------------------------------------------------
module mapa_arbitro
    import mapa_pkg::*;
#(
    parameter int MAPA_WIDTH  = 64,
    parameter int MAPA_HEIGHT = 48
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               cobra_req,
    input  logic [COORD_W-1:0] cobra_x,
    input  logic [COORD_W-1:0] cobra_y,
    input  logic [DADO_W-1:0]  cobra_dado,
    output logic               cobra_ack,

    input  logic               fruta_req,
    input  logic [COORD_W-1:0] fruta_x,
    input  logic [COORD_W-1:0] fruta_y,
    input  logic [DADO_W-1:0]  fruta_dado,
    output logic               fruta_ack,

    input  logic               obstaculo_req,
    input  logic [COORD_W-1:0] obstaculo_x,
    input  logic [COORD_W-1:0] obstaculo_y,
    input  logic [DADO_W-1:0]  obstaculo_dado,
    output logic               obstaculo_ack,

    input  logic               limpar_start,
    output logic               limpar_busy,
    output logic               limpar_done,

    output logic               mem_we,
    output logic [COORD_W-1:0] mem_x,
    output logic [COORD_W-1:0] mem_y,
    output logic [DADO_W-1:0]  mem_dado,

    output logic               fora_limite
);

    localparam logic [COORD_W-1:0] X_ULT = COORD_W'(MAPA_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_ULT = COORD_W'(MAPA_HEIGHT - 1);

    estado_e            state_q,    state_d;
    logic [2:0]         ack_q,      ack_d;
    logic               mem_we_q,   mem_we_d;
    logic [COORD_W-1:0] mem_x_q,    mem_x_d;
    logic [COORD_W-1:0] mem_y_q,    mem_y_d;
    logic [DADO_W-1:0]  mem_dado_q, mem_dado_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               fora_q,     fora_d;
    logic [COORD_W-1:0] cx_q,       cx_d;
    logic [COORD_W-1:0] cy_q,       cy_d;

    logic               arb_en_s;
    logic [2:0]         elig_s;
    logic [2:0]         grant_s;
    escrita_t           sel_s;
    logic               ultimo_s;
    logic [COORD_W-1:0] nx_s;
    logic [COORD_W-1:0] ny_s;

    // Arbitration only runs in IDLE and loses to a clear request in the same
    // cycle. A requester whose ack is showing is not eligible, so a held
    // request is seen as a fresh write only after its ack has dropped.
    assign arb_en_s = (state_q == ST_IDLE) && !limpar_start;
    assign elig_s   = {obstaculo_req, fruta_req, cobra_req} & ~ack_q & {3{arb_en_s}};

    rr_arbitro3 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (elig_s),
        .grant (grant_s)
    );

    // Route the granted requester's fields to the write path
    always_comb begin
        sel_s = {cobra_x, cobra_y, cobra_dado};
        case (grant_s)
            3'b010:  sel_s = {fruta_x, fruta_y, fruta_dado};
            3'b100:  sel_s = {obstaculo_x, obstaculo_y, obstaculo_dado};
            default: sel_s = {cobra_x, cobra_y, cobra_dado};
        endcase
    end

    // Sweep position: x runs fastest, y advances when x wraps
    always_comb begin
        ultimo_s = (cx_q == X_ULT) && (cy_q == Y_ULT);
        if (cx_q == X_ULT) begin
            nx_s = {COORD_W{1'b0}};
            ny_s = cy_q + 10'd1;
        end else begin
            nx_s = cx_q + 10'd1;
            ny_s = cy_q;
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        ack_d      = 3'b000;
        mem_we_d   = 1'b0;
        mem_x_d    = mem_x_q;
        mem_y_d    = mem_y_q;
        mem_dado_d = mem_dado_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        fora_d     = 1'b0;
        cx_d       = cx_q;
        cy_d       = cy_q;

        case (state_q)
            ST_IDLE: begin
                if (limpar_start) begin
                    // The first sweep write (0,0) goes out in the very next cycle
                    state_d    = ST_LIMPANDO;
                    mem_we_d   = 1'b1;
                    mem_x_d    = {COORD_W{1'b0}};
                    mem_y_d    = {COORD_W{1'b0}};
                    mem_dado_d = NADA;
                    busy_d     = 1'b1;
                    cx_d       = {COORD_W{1'b0}};
                    cy_d       = {COORD_W{1'b0}};
                end else if (grant_s != 3'b000) begin
                    ack_d = grant_s;
                    if (dentro_limite(sel_s.x, MAPA_WIDTH) &&
                        dentro_limite(sel_s.y, MAPA_HEIGHT)) begin
                        mem_we_d   = 1'b1;
                        mem_x_d    = sel_s.x;
                        mem_y_d    = sel_s.y;
                        mem_dado_d = sel_s.dado;
                    end else begin
                        // Acknowledge anyway so the requester is released,
                        // but keep the out-of-range cell off the write port
                        fora_d = 1'b1;
                    end
                end else begin
                    ack_d = 3'b000;
                end
            end

            ST_LIMPANDO: begin
                // cx/cy always name the write currently on the port
                if (ultimo_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cx_d    = {COORD_W{1'b0}};
                    cy_d    = {COORD_W{1'b0}};
                end else begin
                    mem_we_d   = 1'b1;
                    mem_x_d    = nx_s;
                    mem_y_d    = ny_s;
                    mem_dado_d = NADA;
                    busy_d     = 1'b1;
                    cx_d       = nx_s;
                    cy_d       = ny_s;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output and sweep-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ack_q      <= 3'b000;
            mem_we_q   <= 1'b0;
            mem_x_q    <= {COORD_W{1'b0}};
            mem_y_q    <= {COORD_W{1'b0}};
            mem_dado_q <= {DADO_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fora_q     <= 1'b0;
            cx_q       <= {COORD_W{1'b0}};
            cy_q       <= {COORD_W{1'b0}};
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            mem_we_q   <= mem_we_d;
            mem_x_q    <= mem_x_d;
            mem_y_q    <= mem_y_d;
            mem_dado_q <= mem_dado_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fora_q     <= fora_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
        end
    end

    assign cobra_ack     = ack_q[0];
    assign fruta_ack     = ack_q[1];
    assign obstaculo_ack = ack_q[2];
    assign mem_we        = mem_we_q;
    assign mem_x         = mem_x_q;
    assign mem_y         = mem_y_q;
    assign mem_dado      = mem_dado_q;
    assign limpar_busy   = busy_q;
    assign limpar_done   = done_q;
    assign fora_limite   = fora_q;

endmodule

// File: tb/tb_mapa_arbitro.sv
// -----------------------------------------------------------------------------
// tb_mapa_arbitro
// Scoreboard bench for mapa_arbitro on a small 4x3 map. The driver applies
// inputs, a reference model predicts the outcome of each edge and queues the
// expected output event; an independent monitor pops and compares whenever
// the DUT shows any activity.
// -----------------------------------------------------------------------------
module tb_mapa_arbitro;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct {
        int         cyc;
        logic [2:0] ack;
        logic       we;
        int         x;
        int         y;
        int         d;
        logic       busy;
        logic       done;
        logic       fora;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] r_req;
    logic [9:0] r_x [3];
    logic [9:0] r_y [3];
    logic [3:0] r_d [3];
    logic       lstart;

    logic       ack_c, ack_f, ack_o;
    logic       busy, done, we, fora;
    logic [9:0] mx, my;
    logic [3:0] md;
    wire  [2:0] acks = {ack_o, ack_f, ack_c};

    int   checks = 0;
    int   passes = 0;
    int   cyc_n  = 0;
    logic mon_en = 1'b0;
    exp_t expq[$];
    exp_t mon_e;
    logic mon_ok;

    // Reference model state
    logic       clearing;
    int         clr_next;
    int         prio;
    logic [2:0] m_ack;

    always #5 clk = ~clk;

    mapa_arbitro #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H)) dut (
        .clk            (clk),
        .reset          (reset),
        .cobra_req      (r_req[0]),
        .cobra_x        (r_x[0]),
        .cobra_y        (r_y[0]),
        .cobra_dado     (r_d[0]),
        .cobra_ack      (ack_c),
        .fruta_req      (r_req[1]),
        .fruta_x        (r_x[1]),
        .fruta_y        (r_y[1]),
        .fruta_dado     (r_d[1]),
        .fruta_ack      (ack_f),
        .obstaculo_req  (r_req[2]),
        .obstaculo_x    (r_x[2]),
        .obstaculo_y    (r_y[2]),
        .obstaculo_dado (r_d[2]),
        .obstaculo_ack  (ack_o),
        .limpar_start   (lstart),
        .limpar_busy    (busy),
        .limpar_done    (done),
        .mem_we         (we),
        .mem_x          (mx),
        .mem_y          (my),
        .mem_dado       (md),
        .fora_limite    (fora)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        clearing = 1'b0;
        clr_next = 0;
        prio     = 0;
        m_ack    = 3'b000;
    endtask

    // Predict what the coming edge produces from the inputs now applied
    task automatic model_edge();
        exp_t e;
        int   g;
        int   i;
        e.cyc = cyc_n + 1;
        e.ack = 3'b000; e.we = 1'b0; e.x = 0; e.y = 0; e.d = 0;
        e.busy = 1'b0; e.done = 1'b0; e.fora = 1'b0;
        g = -1;
        if (clearing) begin
            if (clr_next == W * H) begin
                clearing = 1'b0;
                e.done   = 1'b1;
            end else begin
                e.we = 1'b1; e.busy = 1'b1;
                e.x = clr_next % W; e.y = clr_next / W; e.d = 0;
                clr_next++;
            end
        end else if (lstart) begin
            clearing = 1'b1;
            e.we = 1'b1; e.busy = 1'b1; e.x = 0; e.y = 0; e.d = 0;
            clr_next = 1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                i = (prio + k) % 3;
                if (g < 0 && r_req[i] && !m_ack[i]) g = i;
            end
            if (g >= 0) begin
                e.ack[g] = 1'b1;
                prio = (g + 1) % 3;
                if (int'(r_x[g]) < W && int'(r_y[g]) < H) begin
                    e.we = 1'b1; e.x = int'(r_x[g]); e.y = int'(r_y[g]); e.d = int'(r_d[g]);
                end else begin
                    e.fora = 1'b1;
                end
            end
        end
        m_ack = e.ack;
        if (e.ack != 3'b000 || e.we || e.busy || e.done || e.fora) expq.push_back(e);
    endtask

    task automatic new_txn(input int i);
        r_req[i] = 1'b1;
        r_x[i]   = ($urandom_range(0, 15) == 0) ? 10'd64 : 10'($urandom_range(0, 5));
        r_y[i]   = 10'($urandom_range(0, 4));
        r_d[i]   = 4'($urandom_range(0, 15));
    endtask

    // mode 0: drop req on ack, 1: keep holding, 2: random traffic
    task automatic after_edge(input int mode);
        for (int i = 0; i < 3; i++) begin
            if (m_ack[i]) begin
                if (mode == 0) r_req[i] = 1'b0;
                else if (mode == 2) begin
                    if ($urandom_range(0, 1) == 1) new_txn(i);
                    else r_req[i] = 1'b0;
                end
            end else if (mode == 2 && !r_req[i] && $urandom_range(0, 2) == 0) begin
                new_txn(i);
            end
        end
        if (mode == 2) lstart = ($urandom_range(0, 79) == 0);
    endtask

    task automatic cycle(input int mode);
        if (reset) model_reset();
        else model_edge();
        @(posedge clk);
        cyc_n++;
        #1;
        after_edge(mode);
    endtask

    // Monitor: compare every cycle in which the DUT shows an output event
    always @(negedge clk) begin
        if (mon_en) begin
            while (expq.size() > 0 && expq[0].cyc < cyc_n) begin
                mon_e = expq.pop_front();
                checks++;
                $display("FAIL missing_event: got nothing expected event of cycle %0d (now %0d)", mon_e.cyc, cyc_n);
            end
            if (acks != 3'b000 || we || busy || done || fora) begin
                checks++;
                if (expq.size() == 0) begin
                    $display("FAIL unexpected_event cyc=%0d: got ack=%b we=%b busy=%b done=%b fora=%b expected no activity",
                             cyc_n, acks, we, busy, done, fora);
                end else begin
                    mon_e  = expq.pop_front();
                    mon_ok = (mon_e.cyc == cyc_n) && (acks === mon_e.ack) && (we === mon_e.we) &&
                             (busy === mon_e.busy) && (done === mon_e.done) && (fora === mon_e.fora);
                    if (mon_e.we && (int'(mx) != mon_e.x || int'(my) != mon_e.y || int'(md) != mon_e.d))
                        mon_ok = 1'b0;
                    if (mon_ok) begin
                        passes++;
                    end else begin
                        $display("FAIL scoreboard cyc=%0d: got ack=%b we=%b x=%0d y=%0d d=%0d busy=%b done=%b fora=%b expected cyc=%0d ack=%b we=%b x=%0d y=%0d d=%0d busy=%b done=%b fora=%b",
                                 cyc_n, acks, we, mx, my, md, busy, done, fora,
                                 mon_e.cyc, mon_e.ack, mon_e.we, mon_e.x, mon_e.y, mon_e.d,
                                 mon_e.busy, mon_e.done, mon_e.fora);
                    end
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        lstart = 1'b0;
        r_req  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            r_x[i] = 10'd0; r_y[i] = 10'd0; r_d[i] = 4'd0;
        end
        model_reset();
        repeat (3) cycle(0);

        // Reset state
        chk("rst_acks", int'(acks), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fora", int'(fora), 0);
        chk("rst_mem_x", int'(mx), 0);
        chk("rst_mem_y", int'(my), 0);
        chk("rst_mem_dado", int'(md), 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single cobra write, latency one
        r_req[0] = 1'b1; r_x[0] = 10'd1; r_y[0] = 10'd2; r_d[0] = 4'd1;
        cycle(0);
        chk("single_ack", int'(ack_c), 1);
        chk("single_we", int'(we), 1);
        chk("single_x", int'(mx), 1);
        chk("single_y", int'(my), 2);
        chk("single_dado", int'(md), 1);
        repeat (2) cycle(0);

        // (5,7) does not fit a 4x3 map: acked but dropped
        r_req[0] = 1'b1; r_x[0] = 10'd5; r_y[0] = 10'd7; r_d[0] = 4'd1;
        cycle(0);
        repeat (2) cycle(0);

        // All three held: strict rotation, one write per cycle
        r_x[0] = 10'd0; r_y[0] = 10'd0; r_d[0] = 4'd1;
        r_x[1] = 10'd1; r_y[1] = 10'd1; r_d[1] = 4'd2;
        r_x[2] = 10'd2; r_y[2] = 10'd2; r_d[2] = 4'd3;
        r_req  = 3'b111;
        repeat (7) cycle(1);
        r_req = 3'b000;
        repeat (3) cycle(0);

        // Clear with fruta pending throughout
        lstart = 1'b1;
        cycle(0);
        lstart = 1'b0;
        r_req[1] = 1'b1; r_x[1] = 10'd2; r_y[1] = 10'd1; r_d[1] = 4'd2;
        repeat (W * H + 4) cycle(0);

        // Out-of-range x on obstaculo
        r_req[2] = 1'b1; r_x[2] = 10'd64; r_y[2] = 10'd0; r_d[2] = 4'd3;
        cycle(0);
        chk("oob_ack", int'(ack_o), 1);
        chk("oob_fora", int'(fora), 1);
        chk("oob_we", int'(we), 0);
        repeat (2) cycle(0);

        // Reset while the fifth clear write is on the port
        lstart = 1'b1;
        cycle(0);
        lstart = 1'b0;
        repeat (4) cycle(0);
        chk("abort_fifth_x", int'(mx), 0);
        chk("abort_fifth_y", int'(my), 1);
        reset = 1'b1;
        cycle(0);
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_we", int'(we), 0);
        for (int k = 0; k < W * H + 2; k++) begin
            chk("abort_no_done", int'(done), 0);
            cycle(0);
        end

        // Random traffic with occasional clears
        repeat (1500) cycle(2);
        r_req  = 3'b000;
        lstart = 1'b0;
        repeat (W * H + 6) cycle(0);
        @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
